win_ctrl: RTL and testbench

Game-result controller sitting directly upstream of the win-screen overlay stage in the VGA pipeline. It turns one-cycle king-capture pulses from the game logic into frame-aligned `white_win` / `black_win` levels for the overlay, so the overlay switches only between frames and never mid-frame. It enforces a minimum display time for the win screen before a new game may start. It also gives the game logic a `game_over` freeze flag.

---
 rtl/win_ctrl_if.sv | 22 ++
 rtl/win_ctrl.sv | 87 ++++++++
 tb/tb_win_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/win_ctrl_if.sv
// VGA timing bundle shared along the display pipeline.
// Carries counters, syncs and blanking flags between stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport in (
    input hcount, vcount,
    input hsync, vsync,
    input hblnk, vblnk
  );

  modport out (
    output hcount, vcount,
    output hsync, vsync,
    output hblnk, vblnk
  );
endinterface

// File: rtl/win_ctrl.sv
// Game-result controller: turns king-capture pulses into
// frame-aligned win levels and a game_over freeze flag.
module win_ctrl #(
  parameter int MIN_FRAMES = 60
) (
  input  logic clk,
  input  logic rst,
  vga_if.in    vga_in,
  input  logic white_king_taken,
  input  logic black_king_taken,
  input  logic new_game,
  output logic white_win,
  output logic black_win,
  output logic game_over
);

  typedef enum logic [2:0] {
    PLAY,
    PEND_W,
    PEND_B,
    SHOW_W,
    SHOW_B,
    CLEAR
  } state_t;

  localparam logic [7:0] LP_MIN = 8'(MIN_FRAMES);

  state_t     r_state;
  state_t     w_nxt;
  logic       r_vblnk_d;
  logic [7:0] r_frame_cnt;
  logic       w_tick;
  logic       w_cnt_full;
  logic       w_pend;
  logic       w_show;

  assign w_tick     = vga_in.vblnk & ~r_vblnk_d;
  assign w_cnt_full = (r_frame_cnt == LP_MIN);
  assign w_pend     = (r_state == PEND_W) |
                      (r_state == PEND_B);
  assign w_show     = (r_state == SHOW_W) |
                      (r_state == SHOW_B);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      PLAY: begin
        // black king taken means white won; it wins ties
        if (black_king_taken)
          w_nxt = PEND_W;
        else if (white_king_taken)
          w_nxt = PEND_B;
      end
      PEND_W: if (w_tick) w_nxt = SHOW_W;
      PEND_B: if (w_tick) w_nxt = SHOW_B;
      SHOW_W,
      SHOW_B: begin
        if (new_game && w_cnt_full)
          w_nxt = CLEAR;
      end
      CLEAR:  if (w_tick) w_nxt = PLAY;
      default: w_nxt = PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= PLAY;
      r_vblnk_d   <= 1'b0;
      r_frame_cnt <= 8'd0;
      white_win   <= 1'b0;
      black_win   <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_vblnk_d <= vga_in.vblnk;
      white_win <= (w_nxt == SHOW_W);
      black_win <= (w_nxt == SHOW_B);
      game_over <= (w_nxt != PLAY);
      if (w_pend && w_tick)
        r_frame_cnt <= 8'd0;
      else if (w_show && w_tick && !w_cnt_full)
        r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_win_ctrl.sv
// Bench for win_ctrl: directed scenarios with literal checks
// plus a per-cycle comparison against a behavioural model.
module tb_win_ctrl;
  localparam int MINF  = 3;
  localparam int FRAME = 40;
  localparam int ACT   = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wkt = 1'b0;
  logic bkt = 1'b0;
  logic ng  = 1'b0;
  logic ww, bw, go;

  vga_if vga();

  always #5 clk = ~clk;

  win_ctrl #(.MIN_FRAMES(MINF)) dut (
    .clk              (clk),
    .rst              (rst),
    .vga_in           (vga.in),
    .white_king_taken (wkt),
    .black_king_taken (bkt),
    .new_game         (ng),
    .white_win        (ww),
    .black_win        (bw),
    .game_over        (go)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   pos     = 0;
  logic frc_en  = 1'b0;

  task automatic chk(string nm, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Free-running frame generator; blanking at the end of frame.
  initial begin
    vga.hcount = 11'd0;
    vga.vcount = 11'd0;
    vga.hsync  = 1'b0;
    vga.vsync  = 1'b0;
    vga.hblnk  = 1'b0;
    vga.vblnk  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pos = (pos + 1) % FRAME;
      vga.vcount = 11'(pos);
      if (!frc_en)
        vga.vblnk = (pos >= ACT);
    end
  end

  // Model: who won, whether it is still waiting for a frame,
  // whether the overlay is being cleared, and frames shown.
  int   m_win  = 0;
  bit   m_pend = 0;
  bit   m_clr  = 0;
  int   m_fr   = 0;
  logic m_vd   = 1'b0;
  bit   started = 0;

  always @(posedge clk) begin
    automatic bit tick = vga.vblnk & ~m_vd;
    automatic int nw = m_win;
    automatic bit np = m_pend;
    automatic bit nc = m_clr;
    automatic int nf = m_fr;
    if (rst) begin
      nw = 0; np = 0; nc = 0; nf = 0;
      started <= 1;
      m_vd <= 1'b0;
    end else begin
      m_vd <= vga.vblnk;
      if (nc) begin
        if (tick) nc = 0;
      end else if (np) begin
        if (tick) begin np = 0; nf = 0; end
      end else if (nw != 0) begin
        if (ng && nf == MINF) begin
          nw = 0; nc = 1;
        end else if (tick && nf < MINF) begin
          nf = nf + 1;
        end
      end else begin
        if (bkt) begin nw = 1; np = 1; end
        else if (wkt) begin nw = 2; np = 1; end
      end
    end
    m_win  <= nw;
    m_pend <= np;
    m_clr  <= nc;
    m_fr   <= nf;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_white_win", ww, logic'(m_win == 1 && !m_pend));
      chk("model_black_win", bw, logic'(m_win == 2 && !m_pend));
      chk("model_game_over", go, logic'(m_win != 0 || m_clr));
      chk("exclusive_win", logic'(ww & bw), 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rise(string nm);
    automatic logic prev = vga.vblnk;
    automatic bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (vga.vblnk && !prev) done = 1;
      prev = vga.vblnk;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: vblnk rise timeout", nm);
    end
  endtask

  task automatic pulse(ref logic s);
    s = 1'b1;
    step();
    s = 1'b0;
  endtask

  task automatic frames(int n);
    for (int i = 0; i < n; i++) begin
      wait_rise("frames");
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    step(); step(); step();
    chk("rst_ww", ww, 1'b0);
    chk("rst_bw", bw, 1'b0);
    chk("rst_go", go, 1'b0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 60 && pos != 15; i++) step();

    // white wins by capturing the black king mid-frame
    pulse(bkt);
    chk("cap_go", go, 1'b1);
    chk("cap_ww_pend", ww, 1'b0);
    wait_rise("t1");
    chk("ww_before_tick", ww, 1'b0);
    step();
    chk("ww_after_tick", ww, 1'b1);
    chk("bw_stays0", bw, 1'b0);

    pulse(ng);
    chk("ng_cnt0", ww, 1'b1);
    pulse(wkt);
    chk("king_in_show_ww", ww, 1'b1);
    chk("king_in_show_bw", bw, 1'b0);
    frames(1);
    pulse(ng);
    chk("ng_cnt1", ww, 1'b1);
    frames(1);
    pulse(ng);
    chk("ng_cnt2", ww, 1'b1);
    wait_rise("t3");
    pulse(ng);
    chk("ng_same_tick", ww, 1'b1);
    pulse(ng);
    chk("ng_accept_ww", ww, 1'b0);
    chk("ng_accept_go", go, 1'b1);
    pulse(bkt);
    chk("king_in_clear", go, 1'b1);
    chk("king_in_clear_ww", ww, 1'b0);
    wait_rise("clr");
    chk("go_hold", go, 1'b1);
    step();
    chk("go_fall", go, 1'b0);

    // simultaneous captures resolve to white
    step(); step();
    wkt = 1'b1; bkt = 1'b1;
    step();
    wkt = 1'b0; bkt = 1'b0;
    chk("both_go", go, 1'b1);
    pulse(wkt);
    frames(1);
    chk("both_ww", ww, 1'b1);
    chk("both_bw", bw, 1'b0);
    frames(MINF);
    pulse(ng);
    chk("both_end_ww", ww, 1'b0);
    frames(1);
    chk("both_end_go", go, 1'b0);

    // black wins, then reset mid-display
    pulse(wkt);
    frames(1);
    chk("b_show", bw, 1'b1);
    frames(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ww", ww, 1'b0);
    chk("mid_rst_bw", bw, 1'b0);
    chk("mid_rst_go", go, 1'b0);
    pulse(ng);
    chk("post_rst_ng", go, 1'b0);
    pulse(wkt);
    chk("fresh_go", go, 1'b1);
    frames(1);
    chk("fresh_bw", bw, 1'b1);

    // vblnk held high across reset release
    frc_en = 1'b1;
    vga.vblnk = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    pulse(wkt);
    for (int i = 0; i < 5; i++) step();
    chk("held_no_tick_bw", bw, 1'b0);
    chk("held_go", go, 1'b1);
    vga.vblnk = 1'b0;
    step();
    vga.vblnk = 1'b1;
    step();
    chk("held_one_tick", bw, 1'b1);
    for (int i = 0; i < MINF; i++) begin
      pulse(ng);
      chk("held_ng_early", bw, 1'b1);
      vga.vblnk = 1'b0;
      step();
      vga.vblnk = 1'b1;
      step();
    end
    pulse(ng);
    chk("held_ng_accept", bw, 1'b0);
    frc_en = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
